// File: rtl/game_session_ctrl.sv
// Two-player session sequencer above the minigame FSM: debounces start, launches
// each player's run, captures final scores and publishes winner/best for the overlay.
module game_session_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LAUNCH_TIMEOUT  = 255,
  parameter int HANDOFF_FRAMES  = 600,
  parameter int RESULT_FRAMES   = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       vsync,
  input  logic [2:0] game_state,
  input  logic [2:0] game_score,
  output logic       game_start,
  output logic       player_id,
  output logic [2:0] p0_score,
  output logic [2:0] p1_score,
  output logic [2:0] best_score,
  output logic [1:0] winner,
  output logic [2:0] sess_state,
  output logic       err_pulse
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0] GS_IDLE  = 3'd0;
  localparam logic [2:0] GS_READY = 3'd1;
  localparam logic [2:0] GS_SB    = 3'd4;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RUN     = 3'd2,
    S_HANDOFF = 3'd3,
    S_RESULT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic btn_s1_q, btn_s2_q, btn_deb_q, btn_deb_d, btn_prev_q;
  logic vs_s1_q, vs_s2_q, vs_s3_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic press, tick;

  logic       game_start_q, game_start_d;
  logic       player_q, player_d;
  logic [2:0] p0_q, p0_d, p1_q, p1_d, best_q, best_d;
  logic [1:0] winner_q, winner_d;
  logic       err_q, err_d;
  logic       captured_q, captured_d;
  logic [7:0] launch_cnt_q, launch_cnt_d;
  logic [9:0] frame_cnt_q, frame_cnt_d;

  assign press = btn_deb_q & ~btn_prev_q;
  assign tick  = vs_s2_q & ~vs_s3_q;

  // The debounced level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_comb begin
    btn_deb_d = btn_deb_q;
    db_cnt_d  = db_cnt_q;
    if (btn_s2_q == btn_deb_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_deb_d = btn_s2_q;
      db_cnt_d  = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  function automatic logic [1:0] pick_winner(input logic [2:0] a, input logic [2:0] b);
    if (a > b)      return 2'd1;
    else if (b > a) return 2'd2;
    else            return 2'd3;
  endfunction

  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    p0_d         = p0_q;
    p1_d         = p1_q;
    best_d       = best_q;
    captured_d   = captured_q;
    launch_cnt_d = launch_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    err_d        = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (press) begin
          player_d     = 1'b0;
          p0_d         = '0;
          p1_d         = '0;
          launch_cnt_d = '0;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (game_state == GS_READY) begin
          captured_d = 1'b0;
          state_d    = S_RUN;
        end else if (launch_cnt_q == 8'(LAUNCH_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_WAIT;
        end else begin
          launch_cnt_d = launch_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (game_state == GS_SB && !captured_q) begin
          captured_d = 1'b1;
          if (player_q) p1_d = game_score;
          else          p0_d = game_score;
          if (game_score > best_q) best_d = game_score;
        end else if (game_state == GS_IDLE) begin
          frame_cnt_d = '0;
          if (!captured_q) begin
            // FSM fell back to IDLE without a scoreboard: abort, keep old scores.
            err_d   = 1'b1;
            state_d = S_WAIT;
          end else if (!player_q) begin
            state_d = S_HANDOFF;
          end else begin
            state_d = S_RESULT;
          end
        end
      end
      S_HANDOFF: begin
        // A press on the timeout cycle still launches P1.
        if (press) begin
          player_d     = 1'b1;
          launch_cnt_d = '0;
          state_d      = S_LAUNCH;
        end else if (frame_cnt_q == 10'(HANDOFF_FRAMES)) begin
          p1_d        = '0;
          frame_cnt_d = '0;
          state_d     = S_RESULT;
        end else if (tick) begin
          frame_cnt_d = frame_cnt_q + 10'd1;
        end
      end
      S_RESULT: begin
        if (frame_cnt_q == 10'(RESULT_FRAMES)) begin
          player_d = 1'b0;
          state_d  = S_WAIT;
        end else if (tick) begin
          frame_cnt_d = frame_cnt_q + 10'd1;
        end
      end
      default: state_d = S_WAIT;
    endcase

    game_start_d = (state_d == S_LAUNCH);
    winner_d     = winner_q;
    if (state_d == S_WAIT)
      winner_d = 2'd0;
    else if (state_d == S_RESULT && state_q != S_RESULT)
      winner_d = pick_winner(p0_d, p1_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_deb_q    <= 1'b0;
      btn_prev_q   <= 1'b0;
      db_cnt_q     <= '0;
      vs_s1_q      <= 1'b0;
      vs_s2_q      <= 1'b0;
      vs_s3_q      <= 1'b0;
      state_q      <= S_WAIT;
      game_start_q <= 1'b0;
      player_q     <= 1'b0;
      p0_q         <= '0;
      p1_q         <= '0;
      best_q       <= '0;
      winner_q     <= '0;
      err_q        <= 1'b0;
      captured_q   <= 1'b0;
      launch_cnt_q <= '0;
      frame_cnt_q  <= '0;
    end else begin
      btn_s1_q     <= btn_start;
      btn_s2_q     <= btn_s1_q;
      btn_deb_q    <= btn_deb_d;
      btn_prev_q   <= btn_deb_q;
      db_cnt_q     <= db_cnt_d;
      vs_s1_q      <= vsync;
      vs_s2_q      <= vs_s1_q;
      vs_s3_q      <= vs_s2_q;
      state_q      <= state_d;
      game_start_q <= game_start_d;
      player_q     <= player_d;
      p0_q         <= p0_d;
      p1_q         <= p1_d;
      best_q       <= best_d;
      winner_q     <= winner_d;
      err_q        <= err_d;
      captured_q   <= captured_d;
      launch_cnt_q <= launch_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign game_start = game_start_q;
  assign player_id  = player_q;
  assign p0_score   = p0_q;
  assign p1_score   = p1_q;
  assign best_score = best_q;
  assign winner     = winner_q;
  assign sess_state = state_q;
  assign err_pulse  = err_q;

endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
- Two-player session sequencer sitting above the 4-way minigame FSM.
- Debounces the raw start button and issues the FSM `start` request.
- Tracks the game FSM state, captures each player's final score at SCOREBOARD and alternates turns P0 then P1.
- Produces winner and best-score data for the overlay, then idles until the next session.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clk cycles the button must stay stable before a press is accepted (use 8 in simulation).
- LAUNCH_TIMEOUT, 255, max clk cycles `start` is held waiting for the FSM to leave IDLE.
- HANDOFF_FRAMES, 600, frames P1 has to press start before forfeiting.
- RESULT_FRAMES, 180, frames the session result is held before returning to wait.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_start  input  1  raw asynchronous start button, active-high
- vsync  input  1  VGA vsync; frame tick is its rising edge
- game_state  input  3  FSM state code: 0 IDLE, 1 READY, 2 PLAY, 3 ROUND_END, 4 SCOREBOARD
- game_score  input  3  FSM running score, 0..5
- game_start  output  1  start request to FSM
- player_id  output  1  active player: 0 = P0, 1 = P1
- p0_score  output  3  latched P0 final score
- p1_score  output  3  latched P1 final score
- best_score  output  3  highest score captured since reset
- winner  output  2  0 none, 1 P0, 2 P1, 3 tie
- sess_state  output  3  controller state code, for the overlay
- err_pulse  output  1  one-cycle pulse on launch timeout or game abort

Behaviour:
- **Reset:** async on reset=0, all regs clear. Outputs: game_start=0, player_id=0, p0_score=0, p1_score=0, best_score=0, winner=0, sess_state=S_WAIT, err_pulse=0.
- **Button path:**
  - 2-flop synchronizer, then a stability counter; the debounced level updates after DEBOUNCE_CYCLES consecutive equal samples.
  - A press event is a 1-cycle pulse on the debounced rising edge.
  - Presses are ignored except in S_WAIT and S_HANDOFF.
- **Frame tick:** 2-flop synced vsync; tick = 1-cycle pulse on its rising edge. All frame counters advance only on tick.
- **States** (sess_state codes 0..4):
  - S_WAIT(0):
    - On entry: winner=0.
    - On press: player_id=0, p0_score=0, p1_score=0, go to S_LAUNCH.
  - S_LAUNCH(1):
    - game_start=1 (registered, asserted the cycle after entry). Cycle counter starts at 0.
    - When game_state==1: deassert game_start next cycle, go to S_RUN.
    - When the counter reaches LAUNCH_TIMEOUT: err_pulse, game_start=0, go to S_WAIT.
  - S_RUN(2):
    - First cycle game_state==4 after entering S_RUN: latch game_score into p0_score or p1_score per player_id. Update best_score if game_score > best_score (strict).
    - Capture happens exactly once per run (captured flag).
    - When game_state==0 and captured=1:
      - if player_id==0: go to S_HANDOFF;
      - else: go to S_RESULT.
    - When game_state==0 and captured=0 (FSM reset/abort): err_pulse, go to S_WAIT; latched scores keep their values.
  - S_HANDOFF(3):
    - Frame counter cleared on entry.
    - On press: player_id=1, go to S_LAUNCH.
    - When counter reaches HANDOFF_FRAMES: p1_score=0 (forfeit), go to S_RESULT.
    - A press on the same cycle as timeout wins: launch P1.
  - S_RESULT(4):
    - On entry, winner from p0_score vs p1_score: greater gives 1 or 2; equal gives 3.
    - Hold for RESULT_FRAMES ticks, then go to S_WAIT with player_id=0.
    - winner is cleared to 0 on entry to S_WAIT.
- **best_score** persists across sessions; cleared only by reset.
- **Comparisons** are unsigned 3-bit.
- **Counters:** frame counters are 10 bits, the launch counter is 8 bits; none wrap, since each saturates at its threshold and forces a transition.
- game_start is never asserted outside S_LAUNCH.

Test Plan:
- **Reset mid-session:** assert reset=0 while in S_RUN -> all outputs return to reset values immediately (async); after release, sess_state=0 and game_start=0.
- **Debounce** (DEBOUNCE_CYCLES=8):
  - 5-cycle glitch on btn_start -> no transition.
  - 20-cycle press -> S_LAUNCH; game_start=1 until game_state=1, then 0 one cycle later.
- **Full two-player session:** P0 run ends with game_score=4 at SCOREBOARD; P1 presses, run ends with 2 -> p0_score=4, p1_score=2, best_score=4, winner=1. After RESULT_FRAMES ticks -> sess_state=0, winner=0.
- **Tie and best retention:** next session scores 4/4 -> winner=3, best_score stays 4. A later P0 score of 5 -> best_score=5.
- **Launch timeout:** game_state held at 0 -> after LAUNCH_TIMEOUT cycles, err_pulse=1 for one cycle, game_start=0, sess_state=0.
- **Abort and forfeit:**
  - Abort: game_state goes 1 -> 2 -> 0 without reaching 4 -> err_pulse, sess_state=0.
  - Forfeit: P0 scores 3, no P1 press for HANDOFF_FRAMES ticks -> p1_score=0, winner=1.
